// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the oversampling UART receiver.
//   state_t      : receiver FSM states
//   PARITY_*     : accepted values of the PARITY parameter
//   os_div()     : clocks per 16x oversample tick, rounded to nearest
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  localparam logic [31:0] PARITY_NONE = "NONE";
  localparam logic [31:0] PARITY_EVEN = "EVEN";
  localparam logic [31:0] PARITY_ODD  = {8'h00, "ODD"};

  // round(clk / (baud * 16)) in integer arithmetic
  function automatic int os_div(input int clk, input int baud);
    return (clk + baud * 8) / (baud * 16);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if -- received-frame bus of the UART receiver.
//   rx_frame     : last received data word, LSB first on the line
//   rx_done      : one-cycle pulse per completed frame
//   frame_error  : one-cycle pulse with rx_done, stop bit was low
//   parity_error : one-cycle pulse with rx_done, parity mismatch
// master = receiver (drives), slave = consumer.
interface uart_rx_os_if #(
  parameter int FRAME_WD = 8
) ();

  logic [FRAME_WD-1:0] rx_frame;
  logic                rx_done;
  logic                frame_error;
  logic                parity_error;

  modport master (output rx_frame, rx_done, frame_error, parity_error);
  modport slave  (input  rx_frame, rx_done, frame_error, parity_error);

endinterface

// File: rtl/uart_os_tick.sv
// uart_os_tick -- 16x oversample tick generator.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clear : holds the divider at 0 (receiver idle / start edge)
//   tick  : one-cycle pulse every os_div(CLK_FREQUENCE, BAUD_RATE) clocks
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BAUD_RATE     = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int DIV_RAW = os_div(CLK_FREQUENCE, BAUD_RATE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;

  // Tick fires on the last count, so the first tick after clear lands
  // exactly DIV clocks after clear drops.
  assign tick = !clear && (cnt_reg == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os -- 16x oversampling UART receiver.
//   clk     : system clock (rising edge)
//   rst     : synchronous active-high reset
//   uart_rx : asynchronous serial line, idle high
//   rx_bus  : frame output bus (rx_frame, rx_done, frame_error, parity_error)
// Build option: define UART_RX_MAJORITY_EN to decide each bit (including
// the start-bit check) by 2-of-3 majority of ticks 7/8/9; otherwise the
// single tick-8 sample is used.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int          CLK_FREQUENCE = 50_000_000,
  parameter int          BAUD_RATE     = 9600,
  parameter logic [31:0] PARITY        = "NONE",
  parameter int          FRAME_WD      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         uart_rx,
  uart_rx_os_if.master rx_bus
);

  localparam bit HAS_PARITY = (PARITY != PARITY_NONE);
  localparam bit ODD_PARITY = (PARITY == PARITY_ODD);
  localparam int BW         = (FRAME_WD > 1) ? $clog2(FRAME_WD) : 1;

  // os_cnt_reg holds the number of ticks already seen in the current bit,
  // so tick N arrives while os_cnt_reg == N-1.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] EVAL_CNT = 4'd8;  // decide on tick 9
`else
  localparam logic [3:0] EVAL_CNT = 4'd7;  // decide on tick 8
`endif

  state_t              state_reg, state_next;
  logic                sync1_reg, sync2_reg, prev_reg;
  logic [3:0]          os_cnt_reg;
  logic [BW-1:0]       bit_cnt_reg;
  logic [FRAME_WD-1:0] shift_reg, frame_reg;
  logic                par_err_reg;
  logic                done_reg, ferr_reg, perr_reg;
  logic                tick, clear, fall, bit_evt, bit_val;

  assign clear   = (state_reg == S_IDLE);
  assign fall    = prev_reg && !sync2_reg;
  assign bit_evt = tick && (os_cnt_reg == EVAL_CNT);

`ifdef UART_RX_MAJORITY_EN
  // samp_reg[1] = tick 7 sample, samp_reg[0] = tick 8, sync2_reg = tick 9
  logic [1:0] samp_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_reg <= 2'b11;
    end else if (tick) begin
      samp_reg <= {samp_reg[0], sync2_reg};
    end
  end

  assign bit_val = (samp_reg[1] & samp_reg[0]) | (samp_reg[1] & sync2_reg) |
                   (samp_reg[0] & sync2_reg);
`else
  assign bit_val = sync2_reg;
`endif

  uart_os_tick #(
    .CLK_FREQUENCE(CLK_FREQUENCE),
    .BAUD_RATE    (BAUD_RATE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Edges are only looked for in IDLE; a falling edge inside a frame
  // never resynchronises the bit timing.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (fall) state_next = S_START;
      S_START:     if (bit_evt) state_next = bit_val ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_evt && (bit_cnt_reg == BW'(FRAME_WD - 1))) begin
          state_next = HAS_PARITY ? S_PARITY : S_STOP;
        end
      end
      S_PARITY:    if (bit_evt) state_next = S_STOP;
      S_STOP:      if (bit_evt) state_next = bit_val ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (sync2_reg) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      prev_reg    <= 1'b1;
      os_cnt_reg  <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      frame_reg   <= '0;
      par_err_reg <= 1'b0;
      done_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      perr_reg    <= 1'b0;
    end else begin
      sync1_reg <= uart_rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      perr_reg  <= 1'b0;

      if (state_reg == S_IDLE) begin
        os_cnt_reg  <= '0;
        bit_cnt_reg <= '0;
        par_err_reg <= 1'b0;
      end else if (tick) begin
        os_cnt_reg <= os_cnt_reg + 4'd1;  // wraps every 16 ticks = one bit
      end

      if (bit_evt) begin
        case (state_reg)
          S_DATA: begin
            shift_reg   <= {bit_val, shift_reg[FRAME_WD-1:1]};
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
          end
          // even: expected bit = ^data; odd: its complement
          S_PARITY: par_err_reg <= bit_val ^ (^shift_reg) ^ ODD_PARITY;
          S_STOP: begin
            frame_reg <= shift_reg;
            done_reg  <= 1'b1;
            ferr_reg  <= !bit_val;
            perr_reg  <= par_err_reg;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_bus.rx_frame     = frame_reg;
  assign rx_bus.rx_done      = done_reg;
  assign rx_bus.frame_error  = ferr_reg;
  assign rx_bus.parity_error = perr_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int CLK_HZ    = 50_000_000;
  localparam int SLOW_BAUD = 9600;
  localparam int FAST_BAUD = 781_250;   // os_div = 4, 64 clocks per bit
  localparam int SLOW_BIT  = 5216;
  localparam int FAST_BIT  = 64;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_frame;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_slow = 1'b1, rst_fast = 1'b1, rst_even = 1'b1;
  logic line_slow = 1'b1, line_fast = 1'b1, line_even = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt[3] = '{0, 0, 0};
  exp_t q_slow[$], q_fast[$], q_even[$];
  logic prev_done[3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os_if #(.FRAME_WD(8)) bus_slow ();
  uart_rx_os_if #(.FRAME_WD(8)) bus_fast ();
  uart_rx_os_if #(.FRAME_WD(8)) bus_even ();

  uart_rx_os #(.CLK_FREQUENCE(CLK_HZ), .BAUD_RATE(SLOW_BAUD), .PARITY("NONE"), .FRAME_WD(8))
    u_slow (.clk(clk), .rst(rst_slow), .uart_rx(line_slow), .rx_bus(bus_slow));
  uart_rx_os #(.CLK_FREQUENCE(CLK_HZ), .BAUD_RATE(FAST_BAUD), .PARITY("NONE"), .FRAME_WD(8))
    u_fast (.clk(clk), .rst(rst_fast), .uart_rx(line_fast), .rx_bus(bus_fast));
  uart_rx_os #(.CLK_FREQUENCE(CLK_HZ), .BAUD_RATE(FAST_BAUD), .PARITY("EVEN"), .FRAME_WD(8))
    u_even (.clk(clk), .rst(rst_even), .uart_rx(line_even), .rx_bus(bus_even));

  // Reference model: what a correct receiver reports for a transmitted frame.
  function automatic exp_t model(input logic [7:0] d, input bit has_par,
                                 input logic par, input logic stop);
    exp_t e;
    e.data = d;
    e.fe   = (stop == 1'b0);
    e.pe   = has_par && (par != (^d));  // even parity bit = XOR of data
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int idx, input string nm, input logic done,
                     input logic [7:0] frame, input logic fe, input logic pe);
    exp_t e;
    bit   have;
    have = 0;
    if (!done && (fe || pe)) begin
      checks++;
      failures++;
      $display("FAIL %s_stray_flag: fe=%0b pe=%0b without rx_done", nm, fe, pe);
    end
    if (done && prev_done[idx]) begin
      checks++;
      failures++;
      $display("FAIL %s_pulse_width: rx_done high for 2+ cycles, required 1", nm);
    end
    prev_done[idx] = done;
    if (done) begin
      done_cnt[idx]++;
      checks++;
      case (idx)
        0: if (q_slow.size() > 0) begin e = q_slow.pop_front(); have = 1; end
        1: if (q_fast.size() > 0) begin e = q_fast.pop_front(); have = 1; end
        default: if (q_even.size() > 0) begin e = q_even.pop_front(); have = 1; end
      endcase
      if (!have) begin
        failures++;
        $display("FAIL %s_unexpected_done: frame=%02h fe=%0b pe=%0b, required no pulse",
                 nm, frame, fe, pe);
      end else if ({frame, fe, pe} !== {e.data, e.fe, e.pe}) begin
        failures++;
        $display("FAIL %s_frame: got frame=%02h fe=%0b pe=%0b required frame=%02h fe=%0b pe=%0b",
                 nm, frame, fe, pe, e.data, e.fe, e.pe);
      end else begin
        $display("rx[%s] frame=%02h fe=%0b pe=%0b ok", nm, frame, fe, pe);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, "slow", bus_slow.rx_done, bus_slow.rx_frame, bus_slow.frame_error, bus_slow.parity_error);
    mon(1, "fast", bus_fast.rx_done, bus_fast.rx_frame, bus_fast.frame_error, bus_fast.parity_error);
    mon(2, "even", bus_even.rx_done, bus_even.rx_frame, bus_even.frame_error, bus_even.parity_error);
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic v);
    case (idx)
      0:       line_slow = v;
      1:       line_fast = v;
      default: line_even = v;
    endcase
  endtask

  task automatic send(input int idx, input logic [7:0] d, input bit has_par,
                      input logic par, input logic stop, input int period);
    drive(idx, 1'b0);
    clks(period);
    for (int i = 0; i < 8; i++) begin
      drive(idx, d[i]);
      clks(period);
    end
    if (has_par) begin
      drive(idx, par);
      clks(period);
    end
    drive(idx, stop);
    clks(period);
    drive(idx, 1'b1);
  endtask

  task automatic slow_test();
    q_slow.push_back(model(8'hA5, 0, 1'b0, 1'b1));
    send(0, 8'hA5, 0, 1'b0, 1'b1, SLOW_BIT);
    clks(100);
    chk("slow_A5_done_count", 32'(done_cnt[0]), 32'd1);
    chk("slow_A5_hold", 32'(bus_slow.rx_frame), 32'h0000_00A5);
    drive(0, 1'b0);
    clks(2000);
    drive(0, 1'b1);
    clks(3000);
    chk("slow_glitch_no_done", 32'(done_cnt[0]), 32'd1);
    chk("slow_glitch_idle", 32'(u_slow.state_reg), 32'(S_IDLE));
  endtask

  task automatic fast_tests();
    vec_t tbl[8];
    int   base, c0, lat;
    bit   seen;

    // data, parity bit, stop bit, expected frame/fe/pe (even parity)
    tbl[0] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    tbl[1] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1};
    tbl[5] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    tbl[6] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1};
    tbl[7] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.data = tbl[i].exp_frame;
      e.fe   = tbl[i].exp_fe;
      e.pe   = tbl[i].exp_pe;
      q_even.push_back(e);
      send(2, tbl[i].data, 1, tbl[i].par, tbl[i].stop, FAST_BIT);
      clks(FAST_BIT);
    end
    chk("even_table_count", 32'(done_cnt[2]), 32'd8);
    chk("even_hold", 32'(bus_even.rx_frame), 32'h0000_0080);

    // randomized frames against the model
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      logic       st;
      d  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      q_fast.push_back(model(d, 0, 1'b0, st));
      send(1, d, 0, 1'b0, st, FAST_BIT);
      clks(int'($urandom_range(16, 80)));
    end
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      logic       p, st;
      d  = 8'($urandom);
      p  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 5) != 0);
      q_even.push_back(model(d, 1, p, st));
      send(2, d, 1, p, st, FAST_BIT);
      clks(int'($urandom_range(16, 80)));
    end

    // latency: line start edge to rx_done
    q_fast.push_back(model(8'h96, 0, 1'b0, 1'b1));
    seen = 0;
    lat  = -1;
    c0   = cyc;
    fork
      send(1, 8'h96, 0, 1'b0, 1'b1, FAST_BIT);
      begin
        for (int i = 0; i < 800 && !seen; i++) begin
          @(negedge clk);
          if (bus_fast.rx_done) begin
            seen = 1;
            lat  = cyc - c0;
          end
        end
      end
    join
    checks++;
    if (!seen || lat < 609 || lat > 617) begin
      failures++;
      $display("FAIL latency: got %0d clocks (seen=%0b) required 609..617", lat, seen);
    end
    clks(FAST_BIT);

    // break: stop bit low, line held low for three frame times
    base = done_cnt[1];
    q_fast.push_back(model(8'h33, 0, 1'b0, 1'b0));
    drive(1, 1'b0);
    clks(FAST_BIT);
    for (int i = 0; i < 8; i++) begin
      drive(1, (8'h33 >> i) & 1'b1);
      clks(FAST_BIT);
    end
    drive(1, 1'b0);
    clks(FAST_BIT * 31);
    chk("break_one_done", 32'(done_cnt[1] - base), 32'd1);
    drive(1, 1'b1);
    clks(FAST_BIT * 2);
    chk("break_still_one", 32'(done_cnt[1] - base), 32'd1);
    chk("break_idle", 32'(u_fast.state_reg), 32'(S_IDLE));
    q_fast.push_back(model(8'h5A, 0, 1'b0, 1'b1));
    send(1, 8'h5A, 0, 1'b0, 1'b1, FAST_BIT);
    clks(FAST_BIT);
    chk("break_recover", 32'(done_cnt[1] - base), 32'd2);

    // reset during data bit 4 of 0x3C, sender aborts, then a clean 0x5A
    base = done_cnt[1];
    drive(1, 1'b0);
    clks(FAST_BIT);
    for (int i = 0; i < 4; i++) begin
      drive(1, (8'h3C >> i) & 1'b1);
      clks(FAST_BIT);
    end
    drive(1, 1'b1);  // bit 4 of 0x3C
    clks(FAST_BIT / 2);
    rst_fast = 1'b1;
    clks(3);
    chk("rst_mid_outputs", 32'({bus_fast.rx_frame, bus_fast.rx_done, bus_fast.frame_error,
                                bus_fast.parity_error}), 32'd0);
    chk("rst_mid_state", 32'(u_fast.state_reg), 32'(S_IDLE));
    rst_fast = 1'b0;
    clks(FAST_BIT * 4);
    chk("rst_no_done", 32'(done_cnt[1] - base), 32'd0);
    q_fast.push_back(model(8'h5A, 0, 1'b0, 1'b1));
    send(1, 8'h5A, 0, 1'b0, 1'b1, FAST_BIT);
    clks(FAST_BIT);
    chk("rst_recover_count", 32'(done_cnt[1] - base), 32'd1);
    chk("rst_recover_frame", 32'(bus_fast.rx_frame), 32'h0000_005A);

    // +/-3% baud error, back-to-back 0x00 / 0xFF
    base = done_cnt[1];
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] d;
        d = (k % 2 == 1) ? 8'hFF : 8'h00;
        q_fast.push_back(model(d, 0, 1'b0, 1'b1));
        send(1, d, 0, 1'b0, 1'b1, (s == 0) ? 66 : 62);
      end
    end
    clks(FAST_BIT);
    chk("baud_err_count", 32'(done_cnt[1] - base), 32'd8);
  endtask

  initial begin
    clks(5);
    chk("rst_slow_outputs", 32'({bus_slow.rx_frame, bus_slow.rx_done, bus_slow.frame_error,
                                 bus_slow.parity_error}), 32'd0);
    chk("rst_fast_outputs", 32'({bus_fast.rx_frame, bus_fast.rx_done, bus_fast.frame_error,
                                 bus_fast.parity_error}), 32'd0);
    chk("rst_even_outputs", 32'({bus_even.rx_frame, bus_even.rx_done, bus_even.frame_error,
                                 bus_even.parity_error}), 32'd0);
    chk("rst_slow_state", 32'(u_slow.state_reg), 32'(S_IDLE));
    chk("rst_even_state", 32'(u_even.state_reg), 32'(S_IDLE));
    chk("os_div_9600", 32'(os_div(CLK_HZ, SLOW_BAUD)), 32'd326);
    chk("os_div_fast", 32'(os_div(CLK_HZ, FAST_BAUD)), 32'd4);
    rst_slow = 1'b0;
    rst_fast = 1'b0;
    rst_even = 1'b0;
    clks(5);

    fork
      slow_test();
      fast_tests();
    join

    clks(200);
    chk("pending_slow", 32'(q_slow.size()), 32'd0);
    chk("pending_fast", 32'(q_fast.size()), 32'd0);
    chk("pending_even", 32'(q_even.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CLK_FREQUENCE, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate in bit/s.
REQ-003 SHALL have parameter PARITY, default "NONE", meaning "NONE", "EVEN" or "ODD" parity bit after the data bits.
REQ-004 SHALL have parameter FRAME_WD, default 8, meaning number of data bits per frame (5..9).
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; the design is fully synchronous to its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-007 SHALL have port uart_rx, input, 1 bit, meaning the asynchronous serial line (idle high).
REQ-008 SHALL have port rx_frame, output, FRAME_WD bits, meaning the last received data word, LSB received first.
REQ-009 SHALL have port rx_done, output, 1 bit, meaning a one-cycle pulse when a frame completes (good or bad).
REQ-010 SHALL have port frame_error, output, 1 bit, meaning a one-cycle pulse with rx_done when the stop bit is sampled low.
REQ-011 SHALL have port parity_error, output, 1 bit, meaning a one-cycle pulse with rx_done on parity mismatch (always 0 when PARITY="NONE").

Function
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 SHALL generate a 16x oversample tick every OS_DIV = round(CLK_FREQUENCE/(BAUD_RATE*16)) clocks; the divider runs only outside IDLE and restarts at 0 on start-edge detection.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 IDLE -> START on a synchronized falling edge (previous 1, current 0).
REQ-016 START: at tick 8 (mid-bit), a sample of 0 SHALL go to DATA; a sample of 1 SHALL return to IDLE as a false start, with no output pulse.
REQ-017 DATA: SHALL sample at tick 8 of each subsequent bit, every 16 ticks, and shift the sample in LSB first; after FRAME_WD bits go to PARITY if PARITY!="NONE", else to STOP.
REQ-018 PARITY: SHALL sample one bit; mismatch against the even/odd XOR of the data sets the parity flag.
REQ-019 STOP: SHALL sample the stop bit at its mid-point, then in the next clock load rx_frame, pulse rx_done, and pulse frame_error and parity_error as flagged.
REQ-020 After STOP, a stop sample of 1 SHALL go to IDLE; a stop sample of 0 SHALL go to WAIT_HIGH, which exits to IDLE only after the synchronized line is 1 (break handling; no frames are reported while the line stays low).
REQ-021 rx_frame SHALL hold its value between rx_done pulses and SHALL be updated even on frame or parity error.
REQ-022 Latency SHALL be 1 clock from the stop-bit mid-sample to rx_done, plus 2 clocks of synchronizer delay from the line.
REQ-023 A falling edge during START, DATA, PARITY or STOP SHALL be ignored, with no resynchronization.

Reset
REQ-024 While rst=1, the block SHALL hold the state at IDLE, all counters at 0, rx_frame=0, rx_done=0, frame_error=0, parity_error=0, and synchronizer flops at 1.
REQ-025 rst asserted mid-frame SHALL abort the frame with no pulse, and reception SHALL restart on the next falling edge after release.

Configuration
REQ-026 With macro UART_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of the samples at ticks 7, 8 and 9; without it, the single sample at tick 8 SHALL be used.
REQ-027 The START false-start check SHALL use the same sampling rule as the data bits.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum type, the parity string constants, and function os_div(clk, baud) returning OS_DIV.
REQ-029 The oversample tick generator SHALL be the sub-module uart_os_tick (inputs clk, rst, clear; output tick).

Verification
REQ-030 Bench SHALL cover: 50 MHz clock, 9600 baud (OS_DIV=326, bit period 5216 clks), 8N1 frame of 0xA5 -> rx_frame=0xA5, one rx_done pulse, no error flags.
REQ-031 Bench SHALL cover: PARITY="EVEN", frame of 0x07 with parity bit 0 -> rx_done with parity_error=1 and rx_frame=0x07.
REQ-032 Bench SHALL cover: stop bit driven 0, then line held low for 3 frame times -> exactly one rx_done with frame_error=1; no further rx_done until the line returns high and a new frame is sent.
REQ-033 Bench SHALL cover: a 2000-clock low glitch on an idle line -> no rx_done, and the state returns to IDLE.
REQ-034 Bench SHALL cover: rst pulsed during data bit 4 of 0x3C, then a clean 0x5A frame sent -> a single rx_done with rx_frame=0x5A.
REQ-035 Bench SHALL cover: the line driven at +/-3% baud error with back-to-back 0x00/0xFF frames -> all frames received correctly.
